// File: rtl/eth_rx_sfd_align.sv
// Ethernet receive front end: strips preamble/SFD, forwards frame bytes with
// start/last/err framing through a one-byte hold stage, counts dropped frames.
module eth_rx_sfd_align #(
  parameter int PREAMBLE_MIN = 5,
  parameter int PREAMBLE_MAX = 7,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_dv,
  input  logic             rx_er,
  input  logic             ready,
  output logic [7:0]       out,
  output logic             vld,
  output logic             start,
  output logic             last,
  output logic             err,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int PW = $clog2(PREAMBLE_MAX + 1);

  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, DROP} state_t;

  state_t        state;
  logic [PW-1:0] pcnt;
  logic [7:0]    hold;
  logic          hold_vld;
  logic          first;
  logic          err_sticky;

  logic pre_stay;
  logic pre_accept;
  logic drop_evt;

  // Any preamble byte that neither extends nor completes a valid preamble drops the frame.
  always_comb begin
    pre_stay   = 1'b0;
    pre_accept = 1'b0;
    drop_evt   = 1'b0;
    pre_stay   = (rx_data == 8'h55) && !rx_er && (pcnt < PW'(PREAMBLE_MAX));
    pre_accept = (rx_data == 8'hD5) && !rx_er && (pcnt >= PW'(PREAMBLE_MIN)) && ready;
    if (rx_dv) begin
      case (state)
        IDLE:     drop_evt = (rx_data != 8'h55);
        PREAMBLE: drop_evt = !pre_stay && !pre_accept;
        default:  drop_evt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      pcnt       <= '0;
      hold       <= '0;
      hold_vld   <= 1'b0;
      first      <= 1'b0;
      err_sticky <= 1'b0;
      out        <= '0;
      vld        <= 1'b0;
      start      <= 1'b0;
      last       <= 1'b0;
      err        <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      out   <= '0;
      vld   <= 1'b0;
      start <= 1'b0;
      last  <= 1'b0;
      err   <= 1'b0;

      if (drop_evt && (drop_cnt != '1))
        drop_cnt <= drop_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (rx_dv) begin
            if (rx_data == 8'h55) begin
              state <= PREAMBLE;
              pcnt  <= PW'(1);
            end else begin
              state <= DROP;
            end
          end
        end

        PREAMBLE: begin
          if (!rx_dv) begin
            state <= IDLE;
          end else if (pre_stay) begin
            pcnt <= pcnt + 1'b1;
          end else if (pre_accept) begin
            state      <= PAYLOAD;
            first      <= 1'b1;
            hold_vld   <= 1'b0;
            err_sticky <= 1'b0;
          end else begin
            state <= DROP;
          end
        end

        PAYLOAD: begin
          // The held byte is released one cycle late so the final byte can carry last/err.
          if (rx_dv) begin
            hold     <= rx_data;
            hold_vld <= 1'b1;
            if (rx_er)
              err_sticky <= 1'b1;
            if (hold_vld) begin
              out   <= hold;
              vld   <= 1'b1;
              start <= first;
              first <= 1'b0;
            end
          end else begin
            if (hold_vld) begin
              out   <= hold;
              vld   <= 1'b1;
              start <= first;
              last  <= 1'b1;
              err   <= err_sticky;
            end
            hold_vld   <= 1'b0;
            err_sticky <= 1'b0;
            first      <= 1'b0;
            state      <= IDLE;
          end
        end

        DROP: begin
          if (!rx_dv)
            state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/eth_rx_sfd_align.md
# eth_rx_sfd_align

Front-end stage of the Ethernet receive path, sitting between the PHY byte interface and the receive core. Strips the preamble and SFD, then forwards frame bytes as a byte stream with start/last framing. Frames are dropped and counted if the preamble is malformed or the downstream core is not ready at the SFD. PHY-side errors inside a frame are carried to the frame's last byte.

## Interface
- PREAMBLE_MIN, 5: minimum number of 0x55 bytes required before SFD.
- PREAMBLE_MAX, 7: maximum number of 0x55 bytes accepted before SFD.
- CNT_W, 16: width of the dropped-frame counter.

- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- rx_data  in  8  PHY receive byte.
- rx_dv  in  1  PHY data valid; high for the whole frame, including preamble.
- rx_er  in  1  PHY receive error; qualified by rx_dv.
- ready  in  1  downstream core can accept a new frame; sampled only at SFD.
- out  out  8  frame byte (first byte after SFD onward).
- vld  out  1  out valid; one-cycle strobe per byte.
- start  out  1  high with vld on the first byte of a frame.
- last  out  1  high with vld on the final byte of a frame.
- err  out  1  high with last if rx_er was seen during payload.
- drop_cnt  out  CNT_W  dropped-frame count; saturating.

## Operation
- FSM states and transitions:
  - IDLE
    - rx_dv=1 and rx_data=0x55 -> PREAMBLE, pcnt=1.
    - rx_dv=1, any other byte -> DROP, drop_cnt+1.
  - PREAMBLE
    - rx_dv=0 -> IDLE; no count.
    - 0x55 with pcnt<PREAMBLE_MAX -> pcnt+1.
    - 0x55 with pcnt=PREAMBLE_MAX -> DROP, +1.
    - 0xD5 with pcnt>=PREAMBLE_MIN and ready=1 -> PAYLOAD; first flag set.
    - 0xD5 with ready=0 -> DROP, +1.
    - Any other byte, or 0xD5 with pcnt<PREAMBLE_MIN -> DROP, +1.
    - rx_er=1 in PREAMBLE -> DROP, +1.
  - PAYLOAD
    - Each rx_dv=1 byte is captured into a one-byte hold register (hold_vld). The previously held byte is emitted with vld=1, start=first, last=0; first then clears.
    - rx_dv=0 -> emit held byte with last=1, err=err_sticky; -> IDLE; clear err_sticky.
    - rx_er=1 with rx_dv=1 sets err_sticky.
  - DROP
    - Stay until rx_dv=0, then -> IDLE. No output.
- Zero-length frame (rx_dv falls right after SFD): no output, no count, -> IDLE.
- One-byte frame: single strobe with start=1 and last=1.
- drop_cnt saturates at all-ones; never wraps.
- ready is ignored outside the SFD cycle. An accepted frame is never backpressured.

## Timing
- Reset (rst=0 at edge): out=0, vld=0, start=0, last=0, err=0, drop_cnt=0, state=IDLE, hold cleared.
- Reset mid-frame: all outputs are cleared at the next edge. The partial frame is discarded without last and without a count. After reset, the FSM waits in IDLE; remaining bytes of the frame with rx_dv=1 are not 0x55-first, so they go to DROP and count +1.
- Latency: a payload byte sampled at edge k appears on out with vld after edge k+1, i.e. a 2-cycle latency.
- vld is high for exactly one cycle per byte. Output bytes are gap-free while rx_dv stays high.
- Back-to-back frames: a single rx_dv=0 cycle between frames is sufficient. The last byte of frame N and preamble detection of frame N+1 do not conflict.
- Outputs other than drop_cnt are 0 whenever vld=0.

## Test plan
- 7×0x55, 0xD5, payload 0x01..0x40 (64 bytes), ready=1 -> 64 vld strobes. start on 0x01, last on 0x40, err=0, drop_cnt=0. First strobe comes 2 cycles after 0x01 is on rx_data.
- Same frame, ready=0 at SFD -> no vld, drop_cnt=1. A following good frame with ready=1 is delivered intact.
- Preamble faults -> no output, drop_cnt=3:
  - 4×0x55 then 0xD5 (short).
  - 8×0x55 (long).
  - 0x55,0x55,0x33.
- rx_er pulsed on 3rd payload byte of a 10-byte frame -> 10 strobes; err=1 only with last on byte 10.
- Edge cases:
  - One-byte payload 0xAB -> single strobe with start=last=1.
  - Zero-length frame -> no strobe, drop_cnt unchanged.
  - Frames separated by one idle cycle -> both delivered.
- rst=0 in the middle of payload byte 5 of a frame -> outputs 0 next cycle. Remainder of that frame dropped, drop_cnt=1. Next good frame delivered normally. Preload drop_cnt to all-ones and drop a frame -> stays all-ones.
